pcie_bas_wr_arbiter: RTL and testbench
======================================

Name: pcie_bas_wr_arbiter

Overview:
Burst-aware round-robin arbiter that shares the single PCIe BAS (Avalon-MM burst master) write port among NUM_REQ DMA write requesters. Examples are the RX packet/descriptor DMA engine and the TX completion/notification writers. It sits between the requesters and the PCIe hard-IP BAS port. It never splits or interleaves a burst, and it keeps downstream address, data and control signals stable while waitrequest is asserted.

Parameters:
NUM_REQ, 2, number of write requesters (2..8)
MAX_BURST, 8, largest legal burstcount; sets the width of the beat counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
sw_reset  in  1  synchronous clear of the counters only
req_address  in  NUM_REQ*64  per-requester address; requester i occupies slice [64*i +: 64]
req_byteenable  in  NUM_REQ*64  per-requester byteenable
req_write  in  NUM_REQ  per-requester write request
req_writedata  in  NUM_REQ*512  per-requester write data
req_burstcount  in  NUM_REQ*4  per-requester burstcount; only meaningful on the first beat of a burst
req_waitrequest  out  NUM_REQ  per-requester backpressure
pcie_bas_waitrequest  in  1  downstream backpressure
pcie_bas_address  out  64  downstream address
pcie_bas_byteenable  out  64  downstream byteenable
pcie_bas_write  out  1  downstream write
pcie_bas_writedata  out  512  downstream write data
pcie_bas_burstcount  out  4  downstream burstcount
pcie_bas_read  out  1  tied to 0
protocol_err_cnt  out  32  count of first beats with burstcount==0
arb_wait_cnt  out  32  count of cycles in which at least one ungranted requester has req_write high

Behaviour:
- State machine: IDLE, GRANTED. Registers: sel (index of granted requester), rr_ptr, beats_left (width clog2(MAX_BURST)+1), first_beat flag.
- Reset (rst): state=IDLE, sel=0, rr_ptr=0, beats_left=0, first_beat=1, both counters=0. Outputs follow from this: pcie_bas_write=0 and req_waitrequest all ones.
- rst mid-burst aborts the burst. The downstream side is reset in the same domain.
- sw_reset clears only the two counters. It never alters arbitration state.
- IDLE:
  - pcie_bas_write=0 and every req_waitrequest=1.
  - If any req_write is high, pick the first asserted index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register it into sel, set first_beat=1, go to GRANTED.
  - IDLE always lasts exactly one cycle per grant. Latency from req_write rising to the request appearing on the BAS output is 1 cycle.
- GRANTED:
  - Output mux: pcie_bas_* = req_*[sel], combinational from the registered sel.
  - req_waitrequest[sel] = pcie_bas_waitrequest. All other req_waitrequest bits = 1.
  - A beat is accepted when req_write[sel] && !pcie_bas_waitrequest.
  - First accepted beat: beats_left = burstcount-1. If req_burstcount[sel]==0, treat it as 1 and increment protocol_err_cnt. Clear first_beat.
  - Later accepted beats: decrement beats_left. burstcount on these beats is passed through untouched.
  - When the last beat of the burst is accepted (beats_left evaluates to 0): go to IDLE and set rr_ptr=(sel+1) mod NUM_REQ.
  - If req_write[sel] is low while granted, hold the grant. This waits for the requester's next beat; requesters must complete their bursts.
- Burst lock: the grant never changes mid-burst, even if other requesters assert write.
- Stability: sel changes only in IDLE, so the downstream signals stay stable under waitrequest.
- Fairness: a requester that wins is lowest priority in the next arbitration. Worst-case wait is (NUM_REQ-1) bursts plus one IDLE cycle per burst.
- arb_wait_cnt saturates at 2^32-1. protocol_err_cnt wraps.

Test Plan:
- Single requester: req0 sends a burst of 4 beats, downstream never stalls -> 1 IDLE cycle, then 4 consecutive output beats. Output address equals req0 address and burstcount=4 on the first beat. Back in IDLE after the 4th beat, rr_ptr=1.
- Contention: req0 and req1 both assert single-beat writes at the same time, rr_ptr=0 -> order is req0, req1, req0, ... alternating. Each output beat is separated by one IDLE cycle. req_waitrequest of the loser stays 1.
- Burst lock with stall: req1 sends a burst of 8, pcie_bas_waitrequest held high for 3 cycles on beat 5, req0 writing throughout -> all 8 req1 beats appear in order with signals stable during the stall. req0 is granted only after beat 8. arb_wait_cnt increments on every cycle req0 waits.
- Gap mid-burst: req0 sends a burst of 3 and deasserts write for 2 cycles after beat 1 -> grant held, req1 blocked, 3 beats are delivered in total, then IDLE.
- Error: req1 first beat with burstcount=0 -> treated as a 1-beat burst, protocol_err_cnt=1, IDLE on the next cycle.
- Reset: rst asserted during beat 2 of 4 -> next cycle pcie_bas_write=0, state IDLE, rr_ptr=0, counters 0. sw_reset alone clears the counters only and the grant is unaffected.

Source files
------------

// File: rtl/pcie_bas_wr_arbiter_if.sv
// Bundle of the requester-side write ports and the PCIe BAS write port.
// The arbiter takes the slave view; whoever drives the requesters and the BAS takes the master view.
interface pcie_bas_wr_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ*64-1:0]  req_address;
    logic [NUM_REQ*64-1:0]  req_byteenable;
    logic [NUM_REQ-1:0]     req_write;
    logic [NUM_REQ*512-1:0] req_writedata;
    logic [NUM_REQ*4-1:0]   req_burstcount;
    logic [NUM_REQ-1:0]     req_waitrequest;

    logic                   pcie_bas_waitrequest;
    logic [63:0]            pcie_bas_address;
    logic [63:0]            pcie_bas_byteenable;
    logic                   pcie_bas_write;
    logic [511:0]           pcie_bas_writedata;
    logic [3:0]             pcie_bas_burstcount;
    logic                   pcie_bas_read;

    modport slave (
        input  req_address, req_byteenable, req_write, req_writedata, req_burstcount,
        output req_waitrequest,
        input  pcie_bas_waitrequest,
        output pcie_bas_address, pcie_bas_byteenable, pcie_bas_write,
        output pcie_bas_writedata, pcie_bas_burstcount, pcie_bas_read
    );

    modport master (
        output req_address, req_byteenable, req_write, req_writedata, req_burstcount,
        input  req_waitrequest,
        output pcie_bas_waitrequest,
        input  pcie_bas_address, pcie_bas_byteenable, pcie_bas_write,
        input  pcie_bas_writedata, pcie_bas_burstcount, pcie_bas_read
    );
endinterface

// File: rtl/pcie_bas_wr_arbiter.sv
// Burst-aware round-robin arbiter sharing one PCIe BAS write port among NUM_REQ requesters.
// A grant is held from the first beat of a burst to its last; the winner drops to lowest priority.
module pcie_bas_wr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_reset,
    pcie_bas_wr_arbiter_if.slave bus,
    output logic [31:0]          protocol_err_cnt,
    output logic [31:0]          arb_wait_cnt
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW    = SEL_W + 1;
    localparam int BL_W  = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [SEL_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [BL_W-1:0]    r_beats_left, w_beats_left_nxt;
    logic               r_first_beat, w_first_beat_nxt;
    logic [31:0]        r_protocol_err_cnt;
    logic [31:0]        r_arb_wait_cnt;

    logic [IW-1:0]      w_idx;
    logic [SEL_W-1:0]   w_rr_pick;
    logic               w_any_req;
    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_sel_bc;
    logic               w_zero_bc;
    logic [3:0]         w_bc_m1;
    logic [SEL_W-1:0]   w_sel_inc;
    logic [NUM_REQ-1:0] w_granted_mask;
    logic               w_contend;

    // Round-robin search starting at rr_ptr; descending loop so the closest index wins.
    always_comb begin
        w_idx     = '0;
        w_rr_pick = r_rr_ptr;
        w_any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + IW'(k);
            if (w_idx >= IW'(NUM_REQ)) begin
                w_idx = w_idx - IW'(NUM_REQ);
            end
            if (bus.req_write[w_idx[SEL_W-1:0]]) begin
                w_rr_pick = w_idx[SEL_W-1:0];
                w_any_req = 1'b1;
            end
        end
    end

    assign w_sel_bc  = bus.req_burstcount[4*r_sel +: 4];
    assign w_zero_bc = (w_sel_bc == 4'd0);
    assign w_bc_m1   = (w_zero_bc ? 4'd1 : w_sel_bc) - 4'd1;
    assign w_sel_inc = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
    assign w_accept  = (r_state == ST_GRANTED) && bus.req_write[r_sel] && !bus.pcie_bas_waitrequest;

    // Data path is a pure mux on the registered sel, so it cannot move under waitrequest.
    assign bus.pcie_bas_address    = bus.req_address[64*r_sel +: 64];
    assign bus.pcie_bas_byteenable = bus.req_byteenable[64*r_sel +: 64];
    assign bus.pcie_bas_writedata  = bus.req_writedata[512*r_sel +: 512];
    assign bus.pcie_bas_burstcount = w_sel_bc;
    assign bus.pcie_bas_read       = 1'b0;

    always_comb begin
        w_state_nxt         = r_state;
        w_sel_nxt           = r_sel;
        w_rr_ptr_nxt        = r_rr_ptr;
        w_beats_left_nxt    = r_beats_left;
        w_first_beat_nxt    = r_first_beat;
        w_last              = 1'b0;
        bus.pcie_bas_write  = 1'b0;
        bus.req_waitrequest = '1;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_sel_nxt        = w_rr_pick;
                    w_first_beat_nxt = 1'b1;
                    w_state_nxt      = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                bus.pcie_bas_write         = bus.req_write[r_sel];
                bus.req_waitrequest[r_sel] = bus.pcie_bas_waitrequest;
                if (w_accept) begin
                    if (r_first_beat) begin
                        w_beats_left_nxt = BL_W'(w_bc_m1);
                        w_first_beat_nxt = 1'b0;
                        w_last           = (w_bc_m1 == 4'd0);
                    end else begin
                        w_beats_left_nxt = r_beats_left - 1'b1;
                        w_last           = (r_beats_left == BL_W'(1));
                    end
                    if (w_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = w_sel_inc;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_rr_ptr     <= '0;
            r_beats_left <= '0;
            r_first_beat <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_first_beat <= w_first_beat_nxt;
        end
    end

    // While idle nobody holds a grant, so any asserted write counts as waiting.
    always_comb begin
        w_granted_mask = '0;
        if (r_state == ST_GRANTED) begin
            w_granted_mask[r_sel] = 1'b1;
        end
    end
    assign w_contend = |(bus.req_write & ~w_granted_mask);

    always_ff @(posedge clk) begin
        if (rst || sw_reset) begin
            r_protocol_err_cnt <= '0;
            r_arb_wait_cnt     <= '0;
        end else begin
            if (w_accept && r_first_beat && w_zero_bc) begin
                r_protocol_err_cnt <= r_protocol_err_cnt + 32'd1;
            end
            if (w_contend && (r_arb_wait_cnt != 32'hFFFF_FFFF)) begin
                r_arb_wait_cnt <= r_arb_wait_cnt + 32'd1;
            end
        end
    end

    assign protocol_err_cnt = r_protocol_err_cnt;
    assign arb_wait_cnt     = r_arb_wait_cnt;
endmodule

// File: tb/tb_pcie_bas_wr_arbiter.sv
// Self-checking bench: scripted and random requester bursts checked every cycle against a
// transaction-level arbitration model, plus literal grant-order and counter expectations.
module tb_pcie_bas_wr_arbiter;
    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_reset;
    logic [31:0] protocol_err_cnt;
    logic [31:0] arb_wait_cnt;

    pcie_bas_wr_arbiter_if #(.NUM_REQ(NR)) bus ();

    pcie_bas_wr_arbiter #(.NUM_REQ(NR), .MAX_BURST(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .sw_reset         (sw_reset),
        .bus              (bus),
        .protocol_err_cnt (protocol_err_cnt),
        .arb_wait_cnt     (arb_wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         req;
        int         start;
        int         len;
        logic [3:0] bc;
        int         gap_after;
        int         gap_len;
    } burst_t;

    burst_t sched[$];

    int left[NR];
    int done[NR];
    int gapc[NR];
    int gap_after[NR];
    int gap_len[NR];
    bit acc[NR];

    int cyc = 0;
    int t0 = 0;
    int ds_prob = 0;
    int st_lo = 1000000;
    int st_hi = -1;
    bit chk_on = 1'b0;

    int acc_req[$];
    int acc_cyc[$];
    int exp_r[$];
    int exp_c[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: current owner (-1 when nobody holds the port), search start,
    // beats delivered / burst length of the current burst, and the two counters.
    int          m_owner = -1;
    int          m_ptr = 0;
    int          m_done = 0;
    int          m_len = 0;
    logic [31:0] m_err = '0;
    logic [31:0] m_wait = '0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_log(input string nm);
        bit ok;
        ok = (acc_req.size() == exp_r.size()) && (acc_cyc.size() == exp_c.size());
        if (ok) begin
            foreach (exp_r[k]) begin
                if (acc_req[k] != exp_r[k] || acc_cyc[k] != exp_c[k]) ok = 1'b0;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: served reqs %p at cycles %p, expected reqs %p at cycles %p",
                     nm, acc_req, acc_cyc, exp_r, exp_c);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model by one clock.
    task automatic compare_cycle();
        logic [NR-1:0] w;
        logic [NR-1:0] ew;
        logic          dsw;
        logic          ewr;
        logic          waiting;
        logic [3:0]    bc;
        int            pick;
        w   = bus.req_write;
        dsw = bus.pcie_bas_waitrequest;
        ewr = 1'b0;
        ew  = '1;
        if (m_owner >= 0) begin
            ewr         = w[m_owner];
            ew[m_owner] = dsw;
        end
        chk("bas_write", bus.pcie_bas_write, ewr);
        chk("req_waitrequest", bus.req_waitrequest, ew);
        chk("bas_read", bus.pcie_bas_read, 1'b0);
        chk("protocol_err_cnt", protocol_err_cnt, m_err);
        chk("arb_wait_cnt", arb_wait_cnt, m_wait);
        if (ewr) begin
            chk("bas_address", bus.pcie_bas_address, bus.req_address[64*m_owner +: 64]);
            chk("bas_byteenable", bus.pcie_bas_byteenable, bus.req_byteenable[64*m_owner +: 64]);
            chk("bas_writedata", bus.pcie_bas_writedata, bus.req_writedata[512*m_owner +: 512]);
            chk("bas_burstcount", bus.pcie_bas_burstcount, bus.req_burstcount[4*m_owner +: 4]);
        end
        if (bus.pcie_bas_write === 1'b1 && dsw === 1'b0) begin
            pick = -1;
            for (int i = NR - 1; i >= 0; i--) if (bus.req_waitrequest[i] === 1'b0) pick = i;
            acc_req.push_back(pick);
            acc_cyc.push_back(cyc - t0);
        end
        for (int i = 0; i < NR; i++) acc[i] = (i == m_owner) && ewr && !dsw;
        waiting = 1'b0;
        for (int i = 0; i < NR; i++) if (w[i] && i != m_owner) waiting = 1'b1;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_done  = 0;
            m_err   = '0;
            m_wait  = '0;
        end else begin
            if (sw_reset) begin
                m_err  = '0;
                m_wait = '0;
            end else if (waiting && m_wait != 32'hFFFF_FFFF) begin
                m_wait = m_wait + 32'd1;
            end
            if (m_owner < 0) begin
                pick = -1;
                for (int k = NR - 1; k >= 0; k--) if (w[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
                if (pick >= 0) begin
                    m_owner = pick;
                    m_done  = 0;
                end
            end else if (ewr && !dsw) begin
                if (m_done == 0) begin
                    bc    = bus.req_burstcount[4*m_owner +: 4];
                    m_len = (bc == 4'd0) ? 1 : int'(bc);
                    if (bc == 4'd0 && !sw_reset) m_err = m_err + 32'd1;
                end
                m_done++;
                if (m_done == m_len) begin
                    m_ptr   = (m_owner + 1) % NR;
                    m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) compare_cycle();
        end
    end

    task automatic new_beat(input int i, input bit first, input logic [3:0] bc);
        for (int j = 0; j < 16; j++) bus.req_writedata[512*i + 32*j +: 32] = $urandom;
        bus.req_address[64*i +: 64]    = {$urandom, $urandom};
        bus.req_byteenable[64*i +: 64] = {$urandom, $urandom};
        bus.req_burstcount[4*i +: 4]   = first ? bc : 4'($urandom_range(15));
    endtask

    // Requester behaviour: hold a beat until accepted, step through the burst, honour gaps.
    task automatic drv_update();
        int rel;
        rel = cyc - t0;
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                left[i] = 0;
                gapc[i] = 0;
            end else if (acc[i]) begin
                done[i]++;
                left[i]--;
                if (left[i] > 0) begin
                    if (done[i] == gap_after[i]) gapc[i] = gap_len[i];
                    new_beat(i, 1'b0, 4'd0);
                end
            end else if (gapc[i] > 0) begin
                gapc[i]--;
            end
            if (left[i] == 0) begin
                for (int k = 0; k < sched.size(); k++) begin
                    if (sched[k].req == i) begin
                        if (sched[k].start <= rel) begin
                            left[i]      = sched[k].len;
                            done[i]      = 0;
                            gapc[i]      = 0;
                            gap_after[i] = sched[k].gap_after;
                            gap_len[i]   = sched[k].gap_len;
                            new_beat(i, 1'b1, sched[k].bc);
                            sched.delete(k);
                        end
                        break;
                    end
                end
            end
            bus.req_write[i] = (left[i] > 0) && (gapc[i] == 0);
            acc[i] = 1'b0;
        end
        bus.pcie_bas_waitrequest = (rel >= st_lo && rel <= st_hi) || ($urandom_range(99) < ds_prob);
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1;
        drv_update();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic start_test();
        t0 = cyc + 1;
        acc_req.delete();
        acc_cyc.delete();
        st_lo = 1000000;
        st_hi = -1;
    endtask

    task automatic add(input int r, input int st, input int bc, input int ga, input int gl);
        burst_t b;
        b.req = r;
        b.start = st;
        b.bc = 4'(bc);
        b.len = (bc == 0) ? 1 : bc;
        b.gap_after = ga;
        b.gap_len = gl;
        sched.push_back(b);
    endtask

    initial begin
        int total;
        int budget;
        int st;
        bit busy;
        rst = 1'b1;
        sw_reset = 1'b0;
        bus.req_address = '0;
        bus.req_byteenable = '0;
        bus.req_write = '0;
        bus.req_writedata = '0;
        bus.req_burstcount = '0;
        bus.pcie_bas_waitrequest = 1'b0;
        for (int i = 0; i < NR; i++) begin
            left[i] = 0; done[i] = 0; gapc[i] = 0; gap_after[i] = 0; gap_len[i] = 0; acc[i] = 1'b0;
        end
        run(2);
        chk_on = 1'b1;
        pulse_rst();
        chk("reset_bas_write", bus.pcie_bas_write, 1'b0);
        chk("reset_req_waitrequest", bus.req_waitrequest, 3'b111);
        chk("reset_counters", {protocol_err_cnt, arb_wait_cnt}, 64'd0);

        // Single requester, 4-beat burst, no stall.
        start_test();
        add(0, 0, 4, 0, 0);
        run(8);
        exp_r = '{0, 0, 0, 0};
        exp_c = '{1, 2, 3, 4};
        chk_log("single_burst");

        // Two single-beat streams contending from rr_ptr=0.
        pulse_rst();
        start_test();
        for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 0);
        run(16);
        exp_r = '{0, 1, 0, 1, 0, 1, 0};
        exp_c = '{1, 3, 5, 7, 9, 11, 13};
        chk_log("contention_order");
        chk("contention_wait_cnt", arb_wait_cnt, 32'd13);

        // Burst lock: req1 8-beat burst stalled three cycles on beat 5, req0 waiting.
        pulse_rst();
        start_test();
        st_lo = 5;
        st_hi = 7;
        add(1, 0, 8, 0, 0);
        add(0, 1, 1, 0, 0);
        run(16);
        exp_r = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        exp_c = '{1, 2, 3, 4, 8, 9, 10, 11, 13};
        chk_log("burst_lock_stall");
        chk("burst_lock_wait_cnt", arb_wait_cnt, 32'd13);

        // Requester gap after beat 1 of a 3-beat burst; req1 must stay blocked.
        start_test();
        add(0, 0, 3, 1, 2);
        add(1, 1, 1, 0, 0);
        run(10);
        exp_r = '{0, 0, 0, 1};
        exp_c = '{1, 4, 5, 7};
        chk_log("gap_mid_burst");

        // burstcount==0 on a first beat behaves as a single beat and is counted.
        sw_reset = 1'b1;
        cycle();
        sw_reset = 1'b0;
        chk("sw_reset_err_cnt", protocol_err_cnt, 32'd0);
        start_test();
        add(1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0);
        run(6);
        exp_r = '{1, 0};
        exp_c = '{1, 3};
        chk_log("zero_burstcount");
        chk("zero_burstcount_err_cnt", protocol_err_cnt, 32'd1);

        // rst during beat 2 of a 4-beat burst; afterwards rr_ptr must be back at 0.
        start_test();
        add(0, 0, 1, 0, 0);
        add(0, 0, 4, 0, 0);
        add(0, 5, 1, 0, 0);
        add(1, 5, 1, 0, 0);
        run(5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midburst_rst_bas_write", bus.pcie_bas_write, 1'b0);
        chk("midburst_rst_counters", {protocol_err_cnt, arb_wait_cnt}, 64'd0);
        run(8);
        exp_r = '{0, 0, 0, 0, 1};
        exp_c = '{1, 3, 4, 6, 8};
        chk_log("midburst_rst_order");

        // sw_reset mid-burst clears counters only; the grant carries on.
        start_test();
        add(0, 0, 6, 0, 0);
        add(1, 0, 1, 0, 0);
        run(4);
        sw_reset = 1'b1;
        cycle();
        sw_reset = 1'b0;
        chk("sw_reset_wait_cnt", arb_wait_cnt, 32'd0);
        run(8);
        exp_r = '{0, 0, 0, 0, 0, 0, 1};
        exp_c = '{1, 2, 3, 4, 5, 6, 8};
        chk_log("sw_reset_keeps_grant");
        chk("sw_reset_wait_cnt_after", arb_wait_cnt, 32'd4);

        // Random traffic with downstream backpressure, gaps and occasional sw_reset.
        pulse_rst();
        start_test();
        ds_prob = 30;
        total = 0;
        for (int i = 0; i < NR; i++) begin
            st = 0;
            for (int k = 0; k < 25; k++) begin
                int bc;
                int ln;
                st = st + int'($urandom_range(0, 40));
                bc = int'($urandom_range(0, 8));
                ln = (bc == 0) ? 1 : bc;
                add(i, st, bc, int'($urandom_range(1, ln)), int'($urandom_range(0, 3)));
                total += ln;
            end
        end
        budget = 20000;
        busy = 1'b1;
        while (busy && budget > 0) begin
            cycle();
            sw_reset = ($urandom_range(99) == 0);
            budget--;
            busy = (sched.size() != 0);
            for (int i = 0; i < NR; i++) if (left[i] != 0) busy = 1'b1;
        end
        sw_reset = 1'b0;
        run(4);
        chk("random_drain_in_budget", (budget > 0), 1'b1);
        chk("random_beats_delivered", acc_req.size(), total);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
